// File: rtl/seg595_scan_if.sv
// Bundle of the scan-control inputs and 74HC595 drive outputs for seg595_scan.
interface seg595_scan_if #(
    parameter int DIGITS = 8
) ();
    logic                  en;
    logic [4*DIGITS-1:0]   value;
    logic [DIGITS-1:0]     dp;
    logic [DIGITS-1:0]     blank;
    logic                  ds;
    logic                  shclk;
    logic                  stclk;
    logic                  frame_done;

    modport master (
        output en, value, dp, blank,
        input  ds, shclk, stclk, frame_done
    );

    modport slave (
        input  en, value, dp, blank,
        output ds, shclk, stclk, frame_done
    );
endinterface

// File: rtl/seg595_scan.sv
// Multiplexed 7-segment scanner: serialises {digit select, segment byte} into a
// 74HC595 chain one digit per frame, latches it and holds it for HOLD cycles.
module seg595_scan #(
    parameter int DIGITS  = 8,
    parameter int DIV     = 4,
    parameter int HOLD    = 1000,
    parameter bit SEG_INV = 1'b1,
    parameter bit SEL_INV = 1'b0
) (
    input  logic            clk,
    input  logic            rst_n,
    seg595_scan_if.slave    bus
);

    localparam int FB   = 8 + DIGITS;
    localparam int MAXC = (DIV > HOLD) ? DIV : HOLD;
    localparam int CW   = $clog2(MAXC + 1);
    localparam int BW   = $clog2(FB + 1);
    localparam int IW   = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SH_LO = 3'd1,
        ST_SH_HI = 3'd2,
        ST_LATCH = 3'd3,
        ST_HOLD  = 3'd4
    } state_t;

    state_t                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [BW-1:0]         bit_q, bit_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [FB-1:0]         shreg_q, shreg_d;
    logic [4*DIGITS-1:0]   shv_q, shv_d;
    logic [DIGITS-1:0]     shdp_q, shdp_d;
    logic [DIGITS-1:0]     shbl_q, shbl_d;
    logic                  ds_q, ds_d;
    logic                  shclk_q, shclk_d;
    logic                  stclk_q, stclk_d;
    logic                  fdone_q, fdone_d;

    logic                  load_s;
    logic [IW-1:0]         load_idx_s;
    logic [4*DIGITS-1:0]   src_v_s;
    logic [DIGITS-1:0]     src_dp_s;
    logic [DIGITS-1:0]     src_bl_s;

    function automatic logic [6:0] hex7(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0:    s = 7'h3F;
            4'h1:    s = 7'h06;
            4'h2:    s = 7'h5B;
            4'h3:    s = 7'h4F;
            4'h4:    s = 7'h66;
            4'h5:    s = 7'h6D;
            4'h6:    s = 7'h7D;
            4'h7:    s = 7'h07;
            4'h8:    s = 7'h7F;
            4'h9:    s = 7'h6F;
            4'hA:    s = 7'h77;
            4'hB:    s = 7'h7C;
            4'hC:    s = 7'h39;
            4'hD:    s = 7'h5E;
            4'hE:    s = 7'h79;
            4'hF:    s = 7'h71;
            default: s = 7'h00;
        endcase
        return s;
    endfunction

    function automatic logic [FB-1:0] build_frame(input logic [3:0] nib, input logic dpb,
                                                  input logic blk, input logic [IW-1:0] ix);
        logic [7:0]        seg;
        logic [DIGITS-1:0] sel;
        seg = blk ? 8'h00 : {dpb, hex7(nib)};
        if (SEG_INV) seg = ~seg;
        else         seg = seg;
        sel = DIGITS'(1) << ix;
        if (SEL_INV) sel = ~sel;
        else         sel = sel;
        return {sel, seg};
    endfunction

    // Next-state, frame loading and registered-output decode.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        bit_d      = bit_q;
        idx_d      = idx_q;
        shreg_d    = shreg_q;
        shv_d      = shv_q;
        shdp_d     = shdp_q;
        shbl_d     = shbl_q;
        load_s     = 1'b0;
        load_idx_s = idx_q;
        src_v_s    = shv_q;
        src_dp_s   = shdp_q;
        src_bl_s   = shbl_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.en) begin
                    load_s  = 1'b1;
                    state_d = ST_SH_LO;
                    cnt_d   = '0;
                    bit_d   = '0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SH_LO: begin
                if (cnt_q == CW'(DIV - 1)) begin
                    cnt_d   = '0;
                    state_d = ST_SH_HI;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_SH_HI: begin
                if (cnt_q == CW'(DIV - 1)) begin
                    cnt_d   = '0;
                    shreg_d = shreg_q << 1;
                    bit_d   = bit_q + BW'(1);
                    if (bit_q == BW'(FB - 1)) state_d = ST_LATCH;
                    else                      state_d = ST_SH_LO;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_LATCH: begin
                if (cnt_q == CW'(DIV - 1)) begin
                    cnt_d   = '0;
                    state_d = ST_HOLD;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_HOLD: begin
                if (cnt_q == CW'(HOLD - 1)) begin
                    cnt_d = '0;
                    idx_d = (idx_q == IW'(DIGITS - 1)) ? '0 : idx_q + IW'(1);
                    if (bus.en) begin
                        load_s     = 1'b1;
                        load_idx_s = idx_d;
                        bit_d      = '0;
                        state_d    = ST_SH_LO;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
                bit_d   = '0;
            end
        endcase

        // Digit 0 opens a scan pass: take a fresh snapshot so the pass is never torn.
        if (load_s) begin
            if (load_idx_s == '0) begin
                src_v_s  = bus.value;
                src_dp_s = bus.dp;
                src_bl_s = bus.blank;
                shv_d    = bus.value;
                shdp_d   = bus.dp;
                shbl_d   = bus.blank;
            end else begin
                src_v_s  = shv_q;
                src_dp_s = shdp_q;
                src_bl_s = shbl_q;
            end
            shreg_d = build_frame(src_v_s[{load_idx_s, 2'b00} +: 4], src_dp_s[load_idx_s],
                                  src_bl_s[load_idx_s], load_idx_s);
        end else begin
            shreg_d = shreg_d;
        end

        ds_d    = ((state_d == ST_SH_LO) || (state_d == ST_SH_HI)) ? shreg_d[FB-1] : 1'b0;
        shclk_d = (state_d == ST_SH_HI);
        stclk_d = (state_d == ST_LATCH);
        fdone_d = (state_d == ST_HOLD) && (cnt_d == CW'(HOLD - 1));
    end

    // State, datapath and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            idx_q   <= '0;
            shreg_q <= '0;
            shv_q   <= '0;
            shdp_q  <= '0;
            shbl_q  <= '0;
            ds_q    <= 1'b0;
            shclk_q <= 1'b0;
            stclk_q <= 1'b0;
            fdone_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            idx_q   <= idx_d;
            shreg_q <= shreg_d;
            shv_q   <= shv_d;
            shdp_q  <= shdp_d;
            shbl_q  <= shbl_d;
            ds_q    <= ds_d;
            shclk_q <= shclk_d;
            stclk_q <= stclk_d;
            fdone_q <= fdone_d;
        end
    end

    assign bus.ds         = ds_q;
    assign bus.shclk      = shclk_q;
    assign bus.stclk      = stclk_q;
    assign bus.frame_done = fdone_q;

endmodule
